// File: rtl/me_unit_if.sv
// Data-SRAM request/response channel used by the memory-access stage.
interface me_unit_if;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  modport master (
    output data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    input  data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );

  modport slave (
    input  data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
           data_sram_addr, data_sram_wdata,
    output data_sram_addr_ok, data_sram_data_ok, data_sram_rdata
  );
endinterface

// File: rtl/me_unit.sv
// Memory-access pipeline stage: issues data-SRAM load/store requests, waits for
// completion, aligns/extends load data and hands the result on to writeback.
module me_unit #(
  parameter int EX_BUS_W = 76,
  parameter int WB_BUS_W = 38
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                EX_Valid,
  input  logic [EX_BUS_W-1:0] EX_to_ME_Bus,
  output logic                ME_Unit_Ready,
  output logic                ME_Valid,
  output logic [WB_BUS_W-1:0] ME_to_WB_Bus,
  input  logic                WB_Unit_Ready,
  output logic [4:0]          ME_fwd_dest,
  me_unit_if.master           sram
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t               state_r, state_nxt_s;
  logic                 me_valid_r;
  logic [EX_BUS_W-1:0]  bus_r;
  logic [31:0]          rbuf_r;

  // Byte enables for a store of the given size at the given low address bits.
  function automatic logic [3:0] store_wstrb(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] w;
    case (size)
      2'd0:    w = 4'b0001 << lo;
      2'd1:    w = lo[1] ? 4'b1100 : 4'b0011;
      default: w = 4'b1111;
    endcase
    return w;
  endfunction

  // Store data replicated across every lane it could occupy.
  function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] w;
    case (size)
      2'd0:    w = {4{d[7:0]}};
      2'd1:    w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Pick the addressed byte/half out of the word and sign- or zero-extend it.
  function automatic logic [31:0] load_ext(input logic [1:0] size, input logic uns,
                                           input logic [1:0] lo, input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lo)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lo[1] ? d[31:16] : d[15:0];
    case (size)
      2'd0:    r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  // Fields of the captured instruction.
  logic [1:0]  size_s;
  logic        uns_s, mem_we_s, mem_re_s, res_from_mem_s, gr_we_s;
  logic [31:0] alu_s, sdata_s, result_s;
  logic [4:0]  dest_s;
  logic        mem_op_s, ready_go_s, capture_s, in_mem_op_s, wb_accept_s, in_req_s;

  assign size_s         = bus_r[75:74];
  assign uns_s          = bus_r[73];
  assign mem_we_s       = bus_r[72];
  assign mem_re_s       = bus_r[71];
  assign alu_s          = bus_r[70:39];
  assign sdata_s        = bus_r[38:7];
  assign res_from_mem_s = bus_r[6];
  assign gr_we_s        = bus_r[5];
  assign dest_s         = bus_r[4:0];

  assign mem_op_s      = mem_we_s | mem_re_s;
  assign ready_go_s    = ~mem_op_s | (state_r == S_DONE);
  assign ME_Unit_Ready = ~me_valid_r | (ready_go_s & WB_Unit_Ready);
  assign ME_Valid      = me_valid_r & ready_go_s;
  assign capture_s     = EX_Valid & ME_Unit_Ready;
  assign in_mem_op_s   = EX_to_ME_Bus[72] | EX_to_ME_Bus[71];
  assign wb_accept_s   = ME_Valid & WB_Unit_Ready;
  assign in_req_s      = (state_r == S_REQ);

  assign result_s     = res_from_mem_s ? load_ext(size_s, uns_s, alu_s[1:0], rbuf_r) : alu_s;
  assign ME_to_WB_Bus = {gr_we_s, dest_s, result_s};
  assign ME_fwd_dest  = (ME_Valid & gr_we_s) ? dest_s : 5'd0;

  // Request fields come from the held bus register and are only driven while requesting.
  assign sram.data_sram_req   = in_req_s;
  assign sram.data_sram_wr    = in_req_s & mem_we_s;
  assign sram.data_sram_size  = in_req_s ? size_s : 2'd0;
  assign sram.data_sram_addr  = in_req_s ? alu_s : 32'h0000_0000;
  assign sram.data_sram_wstrb = (in_req_s & mem_we_s) ? store_wstrb(size_s, alu_s[1:0]) : 4'h0;
  assign sram.data_sram_wdata = (in_req_s & mem_we_s) ? store_wdata(size_s, sdata_s) : 32'h0000_0000;

  // Pipeline valid bit and instruction capture from EX.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      me_valid_r <= 1'b0;
      bus_r      <= '0;
    end else begin
      if (ME_Unit_Ready) me_valid_r <= EX_Valid;
      if (capture_s)     bus_r      <= EX_to_ME_Bus;
    end
  end

  // FSM state and load-response buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_r <= S_IDLE;
      rbuf_r  <= 32'h0000_0000;
    end else begin
      state_r <= state_nxt_s;
      if ((state_r == S_WAIT) && sram.data_sram_data_ok) rbuf_r <= sram.data_sram_rdata;
    end
  end

  // Next-state: request, wait for response, hold result until WB takes it.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (capture_s && in_mem_op_s) state_nxt_s = S_REQ;
        else                          state_nxt_s = S_IDLE;
      end
      S_REQ: begin
        if (sram.data_sram_addr_ok) state_nxt_s = S_WAIT;
        else                        state_nxt_s = S_REQ;
      end
      S_WAIT: begin
        if (sram.data_sram_data_ok) state_nxt_s = S_DONE;
        else                        state_nxt_s = S_WAIT;
      end
      S_DONE: begin
        if (wb_accept_s && capture_s && in_mem_op_s) state_nxt_s = S_REQ;
        else if (wb_accept_s)                        state_nxt_s = S_IDLE;
        else                                         state_nxt_s = S_DONE;
      end
      default: state_nxt_s = S_IDLE;
    endcase
  end

endmodule
